// File: rtl/part_product_accumulator.sv
// Multi-cycle shift-add reduction of an NxN partial-product matrix into a 2N-bit product.
// One matrix is accepted per operation; one row is folded into the accumulator per cycle.
module part_product_accumulator #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0][N-1:0]   in_pp,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [2*N-1:0]        product,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [N-1:0][N-1:0]   r_matrix;
  logic [2*N-1:0]        r_acc;
  logic [CW-1:0]         r_cnt;
  logic                  r_busy;
  logic                  r_out_valid;
  logic                  w_last_row;
  logic                  w_accept;
  logic [2*N-1:0]        w_addend;

  assign w_last_row = (r_cnt == CW'(N - 1));
  assign w_accept   = in_valid && in_ready;
  assign w_addend   = {{N{1'b0}}, r_matrix[r_cnt]} << r_cnt;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = ACC;
      ACC:     if (w_last_row) w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_busy      <= (w_next_state == ACC);
      r_out_valid <= (w_next_state == DONE);
    end
  end

  // The counter stops on the last row so it never wraps within an operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_matrix <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_matrix <= in_pp;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        ACC: begin
          r_acc <= r_acc + w_addend;
          if (!w_last_row) r_cnt <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = rst_n && (r_state == IDLE);
  assign product   = r_acc;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_part_product_accumulator.sv
// Scoreboard bench: stimulus queues expected products, a monitor checks each result as it appears.
module tb_part_product_accumulator;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [7:0][7:0]      in_pp = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [15:0]          product;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 busy;

  int                   checks = 0;
  int                   failures = 0;
  int                   cyc = 0;
  int                   lastAccept = 0;
  logic [15:0]          expQ[$];
  int                   acceptQ[$];
  logic                 prevOv = 1'b0;
  logic [15:0]          heldProduct = '0;

  part_product_accumulator #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_pp     (in_pp),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0][7:0] mkPP(input logic [7:0] a, input logic [7:0] b);
    logic [7:0][7:0] pp;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        pp[i][j] = a[j] & b[i];
    return pp;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Drives one matrix until accepted; expected product and acceptance edge go to the scoreboard.
  task automatic applyStimulus(input logic [7:0][7:0] pp, input logic [15:0] exp);
    int t = 0;
    @(negedge clk);
    in_pp = pp;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
    end else begin
      lastAccept = cyc + 1;
      expQ.push_back(exp);
      acceptQ.push_back(lastAccept);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitForOutput();
    int t = 0;
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) checkOutput("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitIdle();
    int t = 0;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) checkOutput("idle_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: pops on each rising out_valid and checks product stability while held.
  always @(negedge clk) begin
    logic [15:0] e;
    int a;
    if (rst_n && out_valid && !prevOv) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        a = acceptQ.pop_front();
        checkOutput("product", 32'(product), 32'(e));
        checkOutput("latency", 32'(cyc - a), 32'd8);
      end
      heldProduct = product;
    end else if (rst_n && out_valid && prevOv) begin
      checkOutput("product_hold", 32'(product), 32'(heldProduct));
    end
    prevOv = rst_n && out_valid;
  end

  initial begin
    int firstAccept;
    logic [7:0][7:0] pp;

    // Reset with in_valid held high: nothing may be accepted.
    in_pp = mkPP(8'h00, 8'h00);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_product", 32'(product), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_in_ready", 32'(in_ready), 32'd1);
    expQ.push_back(16'h0000);
    acceptQ.push_back(cyc + 1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("first_accept_busy", 32'(busy), 32'd1);
    checkOutput("first_accept_in_ready", 32'(in_ready), 32'd0);
    waitForOutput();
    waitIdle();

    // Back-to-back operations with out_ready high.
    out_ready = 1'b1;
    applyStimulus(mkPP(8'hFF, 8'hAA), 16'hA956);
    firstAccept = lastAccept;
    applyStimulus(mkPP(8'hFF, 8'hFF), 16'hFE01);
    checkOutput("throughput", 32'(lastAccept - firstAccept), 32'd10);
    waitForOutput();
    waitIdle();

    // Rows summed by weight regardless of AND structure.
    pp = '0;
    pp[7] = 8'h01;
    applyStimulus(pp, 16'h0080);
    waitForOutput();
    waitIdle();
    pp = '1;
    applyStimulus(pp, 16'hFE01);
    waitForOutput();
    waitIdle();

    // Backpressure: result held, new matrix ignored while DONE.
    out_ready = 1'b0;
    applyStimulus(mkPP(8'hFF, 8'hAA), 16'hA956);
    waitForOutput();
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_product", 32'(product), 32'hA956);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      in_pp = mkPP(8'hFF, 8'hFF);
      in_valid = (k == 2);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
    checkOutput("bp_release_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_no_accept", 32'(busy), 32'd0);

    // Reset in the middle of accumulation discards the operation.
    applyStimulus(mkPP(8'hFF, 8'hAA), 16'hA956);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    expQ.delete();
    acceptQ.delete();
    @(negedge clk);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_product", 32'(product), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("midrst_rel_ready", 32'(in_ready), 32'd1);
    applyStimulus(mkPP(8'hFF, 8'hFF), 16'hFE01);
    waitForOutput();
    waitIdle();
    @(negedge clk);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
